// File: rtl/conv_layer_stream_if.sv
// -----------------------------------------------------------------------------
// conv_layer_stream_if
//
// Groups every non-clock, non-reset signal of conv_layer_stream into one
// bundle. Each signal keeps the block's own name, so _i and _o read from the
// core's point of view.
//
//   Kernel load : cfg_start_i, coef_i, coef_valid_i -> coef_ready_o,
//                 kernels_ready_o
//   Pixel path  : run_i, px_rdy_i, in_value_i
//   Result path : out_data_o, out_ch_o, out_valid_o, out_last_o, overrun_o
//                 <- out_ready_i
//
// Modports:
//   slave  - the convolution core
//   master - whoever drives configuration and pixels and drains results
// -----------------------------------------------------------------------------
interface conv_layer_stream_if #(
    parameter int NUM_KERNELS = 24,
    parameter int PX_W        = 8,
    parameter int COEF_W      = 8,
    parameter int OUT_W       = 10
);
    localparam int CH_W = $clog2(NUM_KERNELS);

    logic              cfg_start_i;
    logic [COEF_W-1:0] coef_i;
    logic              coef_valid_i;
    logic              coef_ready_o;
    logic              kernels_ready_o;
    logic              run_i;
    logic              px_rdy_i;
    logic [PX_W-1:0]   in_value_i;
    logic [OUT_W-1:0]  out_data_o;
    logic [CH_W-1:0]   out_ch_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              overrun_o;

    modport slave (
        input  cfg_start_i, coef_i, coef_valid_i, run_i, px_rdy_i, in_value_i,
               out_ready_i,
        output coef_ready_o, kernels_ready_o, out_data_o, out_ch_o,
               out_valid_o, out_last_o, overrun_o
    );

    modport master (
        output cfg_start_i, coef_i, coef_valid_i, run_i, px_rdy_i, in_value_i,
               out_ready_i,
        input  coef_ready_o, kernels_ready_o, out_data_o, out_ch_o,
               out_valid_o, out_last_o, overrun_o
    );
endinterface

// File: rtl/conv_layer_stream.sv
// -----------------------------------------------------------------------------
// conv_layer_stream
//
// Runs NUM_KERNELS 3x3 convolution kernels in parallel on one pixel stream and
// emits the per-channel results one at a time over a valid/ready handshake.
//
// Flow:
//   1. A cfg_start_i pulse enters LOAD. NUM_KERNELS*9 coefficient beats are
//      then stored. Beat n goes to kernel n/9, tap n%9, with taps row-major
//      p0..p8.
//   2. ARMED waits for run_i. RUN forwards pixel strobes to the cores.
//   3. Each conv_control core takes 9 pixels (one 3x3 window, row-major) and
//      presents a saturated Q4.6 result.
//   4. When every core has a result, all results are frozen in a snapshot.
//      The snapshot is then sent as channels 0..NUM_KERNELS-1.
//
// Number format: pixels are unsigned integers and coefficients are signed
// Q1.6. Each product therefore already carries 6 fractional bits. The 9-term
// sum is saturated to a signed OUT_W-bit Q4.6 value.
//
// Ports:
//   clk_i     - sole clock, rising edge
//   nreset_i  - asynchronous, active-low reset
//   bus       - conv_layer_stream_if.slave (configuration, pixels, results)
//
// Build option:
//   CONV_RELU_EN - when defined, negative core results are replaced by 0 as
//                  they are captured into the snapshot.
// -----------------------------------------------------------------------------
module conv_layer_stream #(
    parameter int NUM_KERNELS = 24,
    parameter int PX_W        = 8,
    parameter int COEF_W      = 8,
    parameter int OUT_W       = 10
) (
    input logic               clk_i,
    input logic               nreset_i,
    conv_layer_stream_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_KERNELS);
    localparam int TAPS  = 9;
    // 9-bit signed pixel times COEF_W-bit coefficient, plus 4 bits of growth
    // for the 9-term sum.
    localparam int ACC_W = PX_W + COEF_W + 5;

    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_KERNELS - 1);
    localparam logic [3:0]      LAST_TAP = 4'(TAPS - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_RUN
    } state_t;

    state_t state_q, state_d;
    logic   coef_ready, kernels_ready;

    // ---------------------------------------------------------------- FSM
    logic beat, last_beat;
    logic [CH_W-1:0] k_idx_q;
    logic [3:0]      p_idx_q;

    assign beat      = bus.coef_valid_i && (state_q == ST_LOAD);
    assign last_beat = beat && (k_idx_q == LAST_CH) && (p_idx_q == LAST_TAP);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values of the previous cycle, whatever the order
    // of the statements.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement. A path that left one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        coef_ready    = 1'b0;
        kernels_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                coef_ready = 1'b1;
                if (last_beat) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                kernels_ready = 1'b1;
                if (bus.run_i) state_d = ST_RUN;
            end
            ST_RUN: kernels_ready = 1'b1;
            default: ;
        endcase
        // A reload request overrides everything, from every state.
        if (bus.cfg_start_i) state_d = ST_LOAD;
    end

    assign bus.coef_ready_o    = coef_ready;
    assign bus.kernels_ready_o = kernels_ready;

    // ------------------------------------------------------- kernel store
    logic signed [COEF_W-1:0] kernel_q [NUM_KERNELS][TAPS];

    // NOTE: the coefficient store is reset to zero, so a core started after
    // reset never multiplies by unknown values. This costs a reset net on
    // every coefficient flop, and that cost is accepted.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            k_idx_q <= '0;
            p_idx_q <= '0;
            for (int k = 0; k < NUM_KERNELS; k++)
                for (int t = 0; t < TAPS; t++)
                    kernel_q[k][t] <= '0;
        end else if (bus.cfg_start_i) begin
            k_idx_q <= '0;
            p_idx_q <= '0;
        end else if (beat) begin
            kernel_q[k_idx_q][p_idx_q] <= bus.coef_i;
            if (p_idx_q == LAST_TAP) begin
                p_idx_q <= '0;
                k_idx_q <= k_idx_q + CH_W'(1);
            end else begin
                p_idx_q <= p_idx_q + 4'd1;
            end
        end
    end

    // --------------------------------------------------- conv_control cores
    logic                    core_start, core_px;
    logic [NUM_KERNELS-1:0]  core_rdy;
    logic signed [OUT_W-1:0] core_res [NUM_KERNELS];

    assign core_start = (state_q == ST_RUN);
    assign core_px    = bus.px_rdy_i && core_start;

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_conv_control
        logic [3:0]              tap_q;
        logic signed [ACC_W-1:0] acc_q, px_ext, coef_ext, sum;
        logic signed [OUT_W-1:0] res_q, sat;
        logic                    rdy_q;

        always_comb begin
            px_ext   = {{(ACC_W - PX_W){1'b0}}, bus.in_value_i};
            coef_ext = {{(ACC_W - COEF_W){kernel_q[k][tap_q][COEF_W-1]}},
                        kernel_q[k][tap_q]};
            sum      = acc_q + px_ext * coef_ext;
            if (sum > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
            else if (sum < SAT_LO) sat = SAT_LO[OUT_W-1:0];
            else                   sat = sum[OUT_W-1:0];
        end

        // px_rdy_o (rdy_q) stays high from the 9th pixel of a window until
        // the first pixel of the next one. That gives exactly one rising edge
        // per window.
        always_ff @(posedge clk_i or negedge nreset_i) begin
            if (!nreset_i) begin
                tap_q <= '0;
                acc_q <= '0;
                res_q <= '0;
                rdy_q <= 1'b0;
            end else if (!core_start) begin
                tap_q <= '0;
                acc_q <= '0;
                rdy_q <= 1'b0;
            end else if (core_px) begin
                rdy_q <= 1'b0;
                if (tap_q == LAST_TAP) begin
                    tap_q <= '0;
                    acc_q <= '0;
                    res_q <= sat;
                    rdy_q <= 1'b1;
                end else begin
                    tap_q <= tap_q + 4'd1;
                    acc_q <= sum;
                end
            end
        end

        assign core_rdy[k] = rdy_q;
        assign core_res[k] = res_q;
    end

    // ------------------------------------------------- snapshot + serializer
    logic                    all_rdy_q, all_rdy, rise, final_hs, can_capture;
    logic signed [OUT_W-1:0] capture_val [NUM_KERNELS];
    logic signed [OUT_W-1:0] snap_q      [NUM_KERNELS];
    logic [CH_W-1:0]         ch_q;
    logic                    out_valid_q, overrun_q;

    assign all_rdy  = &core_rdy;
    assign rise     = all_rdy && !all_rdy_q;
    assign final_hs = out_valid_q && bus.out_ready_i && (ch_q == LAST_CH);
    // A new result set may replace the snapshot in the same cycle that the
    // last channel of the old set is taken.
    assign can_capture = !out_valid_q || final_hs;

    always_comb begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
`ifdef CONV_RELU_EN
            capture_val[k] = core_res[k][OUT_W-1] ? '0 : core_res[k];
`else
            capture_val[k] = core_res[k];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            all_rdy_q   <= 1'b0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_KERNELS; k++) snap_q[k] <= '0;
        end else begin
            all_rdy_q <= all_rdy;
            if (bus.cfg_start_i) begin
                // Any channels not yet sent are discarded.
                ch_q        <= '0;
                out_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
            end else if (rise && can_capture) begin
                for (int k = 0; k < NUM_KERNELS; k++) snap_q[k] <= capture_val[k];
                ch_q        <= '0;
                out_valid_q <= 1'b1;
            end else begin
                // A set that arrives while the snapshot is still in use is
                // dropped, and the snapshot is left untouched.
                if (rise) overrun_q <= 1'b1;
                if (out_valid_q && bus.out_ready_i) begin
                    if (ch_q == LAST_CH) begin
                        ch_q        <= '0;
                        out_valid_q <= 1'b0;
                    end else begin
                        ch_q <= ch_q + CH_W'(1);
                    end
                end
            end
        end
    end

    assign bus.out_data_o  = snap_q[ch_q];
    assign bus.out_ch_o    = ch_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_last_o  = out_valid_q && (ch_q == LAST_CH);
    assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_stream
//
// Self-checking bench for conv_layer_stream. Kernels and pixel windows come
// from $urandom or from fixed patterns. Each expected channel value is a plain
// 9-term dot product, clamped to the Q4.6 range and, with CONV_RELU_EN, set to
// 0 when negative.
// -----------------------------------------------------------------------------
module tb_conv_layer_stream;
    localparam int NK    = 24;
    localparam int TAPS  = 9;
    localparam int TOTAL = NK * TAPS;

    logic clk = 1'b0;
    logic nreset;

    always #5 clk = ~clk;

    conv_layer_stream_if #(.NUM_KERNELS(NK), .PX_W(8), .COEF_W(8), .OUT_W(10)) bus ();

    conv_layer_stream #(
        .NUM_KERNELS(NK),
        .PX_W       (8),
        .COEF_W     (8),
        .OUT_W      (10)
    ) dut (
        .clk_i   (clk),
        .nreset_i(nreset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int kern [NK][TAPS];
    int px   [TAPS];
    int expv [NK];
    int got  [NK];

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, actual, expected);
        end
    endtask

    // Reference: a 3x3 dot product, clamped to signed 10-bit.
    function automatic int model(input int k);
        int s = 0;
        for (int i = 0; i < TAPS; i++) s += kern[k][i] * px[i];
        if (s > 511)  s = 511;
        if (s < -512) s = -512;
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic void compute_expected();
        for (int k = 0; k < NK; k++) expv[k] = model(k);
    endfunction

    function automatic int sdata();
        return int'($signed(bus.out_data_o));
    endfunction

    function automatic int all_outs();
        return int'({bus.coef_ready_o, bus.kernels_ready_o, bus.out_valid_o,
                     bus.out_last_o, bus.overrun_o, bus.out_ch_o, bus.out_data_o});
    endfunction

    // All tasks start and end just after a falling edge of clk.
    task automatic load_kernels();
        int n = 0;
        int guard = 0;
        bit early = 1'b0;
        bit rdy;
        bus.cfg_start_i = 1'b1;
        @(negedge clk);
        bus.cfg_start_i = 1'b0;
        while (n < TOTAL && guard < 4000) begin
            rdy = bus.coef_ready_o;
            if (bus.kernels_ready_o) early = 1'b1;
            bus.coef_valid_i = 1'($urandom_range(0, 1));
            bus.coef_i       = 8'(kern[n / TAPS][n % TAPS]);
            @(negedge clk);
            if (bus.coef_valid_i && rdy) n++;
            guard++;
        end
        bus.coef_valid_i = 1'b0;
        check("load_beats", n, TOTAL);
        check("kr_before_last", int'(early), 0);
        check("kr_after_last", int'(bus.kernels_ready_o), 1);
        check("coef_ready_after", int'(bus.coef_ready_o), 0);
    endtask

    task automatic pulse_run();
        bus.run_i = 1'b1;
        @(negedge clk);
        bus.run_i = 1'b0;
    endtask

    task automatic feed_window();
        for (int i = 0; i < TAPS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.px_rdy_i   = 1'b1;
            bus.in_value_i = 8'(px[i]);
            @(negedge clk);
            bus.px_rdy_i = 1'b0;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.out_valid_o) ok = 1'b1;
            else @(negedge clk);
        end
        check("out_valid_seen", int'(ok), 1);
    endtask

    // Drains one result set against expv. Holds ready low for stall_n cycles
    // while channel stall_ch is presented.
    task automatic collect(input string tag, input int stall_ch, input int stall_n);
        int idx = 0;
        int guard = 0;
        int left = stall_n;
        bit ok;
        wait_valid(ok);
        while (ok && idx < NK && guard < 1000) begin
            guard++;
            if (bus.out_valid_o && idx == stall_ch && left > 0) begin
                bus.out_ready_i = 1'b0;
                check({tag, "_hold_ch"}, int'(bus.out_ch_o), idx);
                check({tag, "_hold_data"}, sdata(), expv[idx]);
                left--;
            end else begin
                bus.out_ready_i = 1'($urandom_range(0, 3) != 0);
                if (bus.out_ready_i && bus.out_valid_o) begin
                    got[idx] = sdata();
                    check({tag, "_ch"}, int'(bus.out_ch_o), idx);
                    check({tag, "_data"}, got[idx], expv[idx]);
                    check({tag, "_last"}, int'(bus.out_last_o), int'(idx == NK - 1));
                    idx++;
                end
            end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b0;
        check({tag, "_count"}, idx, NK);
        check({tag, "_valid_low"}, int'(bus.out_valid_o), 0);
    endtask

    task automatic random_kernels(input int lo, input int hi);
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < TAPS; i++)
                kern[k][i] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    task automatic random_pixels(input int hi);
        for (int i = 0; i < TAPS; i++) px[i] = int'($urandom_range(0, hi));
    endtask

    initial begin
        bit ok;
        bit seen;

        bus.cfg_start_i  = 1'b0;
        bus.coef_i       = '0;
        bus.coef_valid_i = 1'b0;
        bus.run_i        = 1'b0;
        bus.px_rdy_i     = 1'b0;
        bus.in_value_i   = '0;
        bus.out_ready_i  = 1'b0;
        nreset = 1'b0;
        #1;
        check("reset_outs", all_outs(), 0);
        #20;
        @(negedge clk);
        nreset = 1'b1;

        // run_i in IDLE is ignored.
        pulse_run();
        repeat (2) @(negedge clk);
        check("idle_run_kr", int'(bus.kernels_ready_o), 0);
        check("idle_coef_ready", int'(bus.coef_ready_o), 0);

        // Kernel k = all k+1, pixels of 1. Stall 5 cycles on channel 3.
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < TAPS; i++) kern[k][i] = k + 1;
        load_kernels();
        pulse_run();
        for (int i = 0; i < TAPS; i++) px[i] = 1;
        compute_expected();
        feed_window();
        collect("const", 3, 5);
        check("const_ch23", got[NK-1], 216);
        check("no_overrun", int'(bus.overrun_o), 0);

        // Random windows on the same kernels, then on random kernels.
        for (int r = 0; r < 2; r++) begin
            random_pixels(255);
            compute_expected();
            feed_window();
            collect("rnd_px", -1, 0);
        end
        random_kernels(-128, 127);
        load_kernels();
        pulse_run();
        random_pixels(15);
        compute_expected();
        feed_window();
        collect("rnd_small", -1, 0);
        random_pixels(255);
        compute_expected();
        feed_window();
        collect("rnd_full", -1, 0);

        // A second result set while the first is still waiting is dropped.
        random_pixels(255);
        compute_expected();
        feed_window();
        for (int i = 0; i < TAPS; i++) px[i] = (px[i] + 37) % 256;
        feed_window();
        repeat (2) @(negedge clk);
        check("overrun_set", int'(bus.overrun_o), 1);
        collect("overrun", -1, 0);
        check("overrun_sticky", int'(bus.overrun_o), 1);

        // cfg_start_i mid-serialization.
        random_pixels(255);
        compute_expected();
        feed_window();
        wait_valid(ok);
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready_i = 1'b0;
        bus.cfg_start_i = 1'b1;
        @(negedge clk);
        bus.cfg_start_i = 1'b0;
        check("cfg_mid_valid", int'(bus.out_valid_o), 0);
        check("cfg_mid_overrun", int'(bus.overrun_o), 0);

        // Kernel 0 all -1, pixel 0x10: -144 unless ReLU is enabled.
        random_kernels(-4, 4);
        for (int i = 0; i < TAPS; i++) kern[0][i] = -1;
        load_kernels();
        pulse_run();
        for (int i = 0; i < TAPS; i++) px[i] = 16;
        compute_expected();
        feed_window();
        collect("relu", -1, 0);
`ifdef CONV_RELU_EN
        check("relu_ch0", got[0], 0);
`else
        check("relu_ch0", got[0], -144);
`endif

        // Reset mid-LOAD, then run_i must be ignored.
        bus.cfg_start_i = 1'b1;
        @(negedge clk);
        bus.cfg_start_i  = 1'b0;
        bus.coef_valid_i = 1'b1;
        repeat (20) @(negedge clk);
        #2 nreset = 1'b0;
        #1 check("rst_load_outs", all_outs(), 0);
        @(negedge clk);
        nreset = 1'b1;
        bus.coef_valid_i = 1'b0;
        pulse_run();
        feed_window();
        seen = 1'b0;
        repeat (20) begin
            if (bus.out_valid_o || bus.kernels_ready_o) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_run_ignored", int'(seen), 0);

        // Reset mid-serialization.
        random_kernels(-128, 127);
        load_kernels();
        pulse_run();
        random_pixels(255);
        feed_window();
        wait_valid(ok);
        bus.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready_i = 1'b0;
        #2 nreset = 1'b0;
        #1 check("rst_ser_outs", all_outs(), 0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ser_idle", int'(bus.kernels_ready_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
